// File: rtl/xs3_pkg.sv
// Shared excess-3 constants and the scan state encoding for the display controller.
package xs3_pkg;
  localparam logic [3:0] XS3_ZERO = 4'b0011;
  localparam logic [3:0] XS3_MIN  = 4'b0011;
  localparam logic [3:0] XS3_MAX  = 4'b1100;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;
endpackage

// File: rtl/xs3_dec10.sv
// Excess-3 to one-of-ten decoder with active-low outputs; invalid codes leave all lines high.
module xs3_dec10
  import xs3_pkg::*;
(
  input  logic [3:0] code,
  output logic [9:0] seg_n,
  output logic       valid
);

  always_comb begin
    seg_n = '1;
    valid = (code >= XS3_MIN) && (code <= XS3_MAX);
    for (int unsigned i = 0; i < 10; i++) begin
      if (code == XS3_MIN + 4'(i)) seg_n[i] = 1'b0;
    end
  end

endmodule

// File: rtl/xs3_scan_display_ctrl.sv
// Multiplexed excess-3 display scanner with double-buffered digit bank and frame-aligned commit.
module xs3_scan_display_ctrl
  import xs3_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  input  logic                          commit,
  output logic                          commit_done,
  output logic [9:0]                    seg_n,
  output logic [NUM_DIGITS-1:0]         dig_n,
  output logic                          err_flag,
  input  logic                          err_clr
);

  localparam int AW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [AW-1:0] CUR_LAST   = AW'(NUM_DIGITS - 1);

  scan_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [AW-1:0] cur, cur_next;

  logic [3:0] shadow [NUM_DIGITS];
  logic [3:0] active [NUM_DIGITS];

  logic       commit_pending;
  logic       frame_boundary;
  logic       show_entry;
  logic       wr_fire;
  logic       wr_in_range;
  logic [3:0] cur_code;
  logic [9:0] dec_seg;
  logic       dec_valid;

  assign wr_ready    = !commit_pending;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = {1'b0, wr_addr} < (AW + 1)'(NUM_DIGITS);
  assign commit_done = frame_boundary && commit_pending;
  assign cur_code    = active[cur];

  xs3_dec10 u_dec (
    .code  (cur_code),
    .seg_n (dec_seg),
    .valid (dec_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cur   <= cur_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cur_next   = cur;
    show_entry = 1'b0;
    // The wrap from the last digit counts as a frame end even if enable drops in that
    // cycle; the copy is harmless and the following IDLE cycle finds nothing pending.
    frame_boundary = (state == IDLE) ||
                     ((state == SHOW) && (cnt == DWELL_LAST) && (cur == CUR_LAST));
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
      cur_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_next = BLANK;
          cnt_next   = '0;
          cur_next   = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_next = SHOW;
            cnt_next   = '0;
            show_entry = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == DWELL_LAST) begin
            state_next = BLANK;
            cnt_next   = '0;
            cur_next   = (cur == CUR_LAST) ? '0 : cur + 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          cur_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= XS3_ZERO;
        active[i] <= XS3_ZERO;
      end
    end else begin
      if (wr_fire && wr_in_range) shadow[wr_addr] <= wr_data;
      if (commit_done) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pending <= 1'b0;
      err_flag       <= 1'b0;
      seg_n          <= '1;
      dig_n          <= '1;
    end else begin
      if (commit_done)  commit_pending <= 1'b0;
      else if (commit)  commit_pending <= 1'b1;

      if (show_entry && !dec_valid) err_flag <= 1'b1;
      else if (err_clr)             err_flag <= 1'b0;

      seg_n <= (state == SHOW) ? dec_seg : '1;
      dig_n <= (state == SHOW) ? ~(NUM_DIGITS'(1) << cur) : '1;
    end
  end

endmodule
